// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request scheduler:
//   DW, OPW   - ALU data and opcode widths
//   alu_op_e  - opcode encoding, identical to the ALU's own select encoding
//   state_e   - scheduler FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW  = 8;
  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_MIN  = 4'd13,
    OP_MAX  = 4'd14,
    OP_HAMM = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the grant goes to the first asserted
// req bit at or after ptr, wrapping from NREQ-1 back to 0. The pointer register
// itself lives in the parent.
// Ports:
//   req       in  NREQ        request vector
//   ptr       in  clog2(NREQ) highest-priority index (must be < NREQ)
//   grant     out NREQ        one-hot grant, all 0 when no request
//   grant_idx out clog2(NREQ) index of the granted bit (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  // One extra bit so ptr + offset never overflows before the wrap subtraction;
  // this avoids a modulo operator for non-power-of-two NREQ.
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // NOTE: every signal written here gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// -----------------------------------------------------------------------------
// alu_req_sched
// Shares one external combinational 8-bit ALU between NREQ requesters.
// Round-robin arbitration, registered operands toward the ALU and a registered
// result back. One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   TAGW  request/response tag width
//   CNTW  grant-counter width (statistics build only)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (ready is one-hot)
//   req_a/b/oper/tag       packed per-requester request fields, slice i = req i
//   rsp_valid/rsp_ready    per-requester response handshake
//   rsp_data/tag/dz        shared response payload, stable while in RESP
//   alu_a/b/oper, alu_out  connection to the external ALU
//   grant_cnt              per-requester saturating grant counters
// Build option:
//   ALU_REQ_SCHED_STATS_EN adds the grant_cnt port and its counters.
// -----------------------------------------------------------------------------
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*OPW-1:0]  req_oper,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 rsp_dz,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [OPW-1:0]       alu_oper,
  input  logic [DW-1:0]        alu_out
`ifdef ALU_REQ_SCHED_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0] grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            accept;
  logic            rsp_done;

  logic [DW-1:0]   sel_a, sel_b;
  logic [OPW-1:0]  sel_oper;
  logic [TAGW-1:0] sel_tag;

  logic [DW-1:0]   a_q, b_q, data_q;
  logic [OPW-1:0]  oper_q;
  logic [TAGW-1:0] tag_q;
  logic            dz_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshakes are combinational: ready only exists in IDLE, rsp_valid only
  // in RESP, so a reset (state -> IDLE) drops any pending response at once.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = req_valid & grant;
        if (|(req_valid & grant)) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[win_q] = 1'b1;
        // Only the winner's rsp_ready matters; other bits are ignored.
        if (rsp_ready[win_q]) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request field mux driven by the one-hot grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_oper = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[i*DW +: DW];
        sel_b    = req_b[i*DW +: DW];
        sel_oper = req_oper[i*OPW +: OPW];
        sel_tag  = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      win_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      oper_q <= '0;
      tag_q  <= '0;
      data_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        oper_q <= sel_oper;
        tag_q  <= sel_tag;
        win_q  <= grant_idx;
      end
      if (state_q == EXEC) begin
        // Division by zero is resolved here; whatever the ALU returns is dropped.
        if (oper_q == OP_DIV && b_q == '0) begin
          data_q <= '1;
          dz_q   <= 1'b1;
        end else begin
          data_q <= alu_out;
          dz_q   <= 1'b0;
        end
      end
      if (rsp_done) begin
        ptr_q <= (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  // Operand registers feed the ALU directly; they only change on acceptance,
  // so the ALU sees stable inputs throughout EXEC.
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_oper = oper_q;
  assign rsp_data = data_q;
  assign rsp_tag  = tag_q;
  assign rsp_dz   = dz_q;

`ifdef ALU_REQ_SCHED_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNTW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (accept && grant[i] && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_cnt[i*CNTW +: CNTW] = cnt_q;
  end
`endif

endmodule
